// File: rtl/rbm_layer_par.sv
// One hidden layer of a restricted Boltzmann machine. LANES hidden units are evaluated in parallel,
// CHUNK visible inputs per cycle, with either a deterministic threshold or stochastic sampling.
module rbm_layer_par #(
    parameter int unsigned IN_DIM   = 15,
    parameter int unsigned OUT_DIM  = 5,
    parameter int unsigned W_BITS   = 12,
    parameter int unsigned SIG_BITS = 8,
    parameter int unsigned CHUNK    = 4,
    parameter int unsigned LANES    = 2,
    parameter logic [7:0]  SEED     = 8'h20,
    localparam int unsigned NW      = IN_DIM * OUT_DIM,
    localparam int unsigned AW      = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                mode_i,
    input  logic [IN_DIM-1:0]   in_data_i,
    input  logic                wr_en_i,
    input  logic                wr_bias_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [W_BITS-1:0]   wr_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [OUT_DIM-1:0]  out_data_o
);

    localparam int unsigned K     = (IN_DIM + CHUNK - 1) / CHUNK;
    localparam int unsigned G     = (OUT_DIM + LANES - 1) / LANES;
    localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned GW    = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned IW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int unsigned OW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int unsigned CW    = (SIG_BITS > 8) ? SIG_BITS : 8;
    // Arithmetic shift chosen so that the most negative accumulator lands below zero.
    localparam int unsigned SHIFT = (W_BITS > SIG_BITS) ? (W_BITS - SIG_BITS - 1) : 0;
    localparam int          SIG_TOP = (1 << SIG_BITS) - 1;

    typedef logic signed [W_BITS-1:0] acc_t;

    localparam acc_t ACC_MIN = {1'b1, {(W_BITS - 1){1'b0}}};
    localparam acc_t ACC_MAX = {1'b0, {(W_BITS - 1){1'b1}}};

    typedef enum logic [2:0] {
        StIdle,
        StBias,
        StAccum,
        StDecide,
        StDone
    } state_e;

    state_e              state_q;
    logic                busy_q;
    logic                done_q;
    logic [OUT_DIM-1:0]  out_q;
    logic [IN_DIM-1:0]   in_q;
    logic                mode_q;
    logic [GW-1:0]       group_q;
    logic [KW-1:0]       kcnt_q;
    acc_t                acc_q   [LANES];
    logic [7:0]          lfsr_q  [LANES];

    acc_t                w_mem_q [NW];
    acc_t                b_mem_q [OUT_DIM];

    logic [LANES-1:0]    lane_ok;
    logic [OW-1:0]       lane_unit [LANES];
    acc_t                bias_val  [LANES];
    acc_t                acc_d     [LANES];
    logic [LANES-1:0]    dec_bit;

    function automatic acc_t sat_add(acc_t a, acc_t b);
        logic signed [W_BITS:0] s;
        s = {a[W_BITS-1], a} + {b[W_BITS-1], b};
        if (s[W_BITS] != s[W_BITS-1]) begin
            return s[W_BITS] ? ACC_MIN : ACC_MAX;
        end
        return s[W_BITS-1:0];
    endfunction

    // Piecewise-linear sigmoid: scaled accumulator re-centred on mid-scale, then clamped.
    function automatic logic [SIG_BITS-1:0] sigmoid(acc_t a);
        int v;
        v = int'(a >>> SHIFT) + (1 << (SIG_BITS - 1));
        if (a == ACC_MIN || v <= 0) begin
            return '0;
        end
        if (v >= SIG_TOP) begin
            return '1;
        end
        return SIG_BITS'(v);
    endfunction

    function automatic logic [7:0] lfsr_seed(int l);
        logic [7:0] s;
        s = SEED ^ 8'(l);
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    function automatic logic [7:0] lfsr_step(logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Parameter storage survives reset; only accepted while idle.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && state_q == StIdle) begin
            if (wr_bias_i) begin
                if (32'(wr_addr_i) < OUT_DIM) begin
                    b_mem_q[OW'(wr_addr_i)] <= wr_data_i;
                end
            end else if (32'(wr_addr_i) < NW) begin
                w_mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    always_comb begin
        int unsigned unit;
        unit = 0;
        for (int l = 0; l < LANES; l++) begin
            unit         = 32'(group_q) * LANES + 32'(l);
            lane_ok[l]   = (unit < OUT_DIM);
            lane_unit[l] = OW'(unit);
            bias_val[l]  = lane_ok[l] ? b_mem_q[lane_unit[l]] : '0;
            dec_bit[l]   = mode_q ? ~acc_q[l][W_BITS-1]
                                  : (CW'(sigmoid(acc_q[l])) > CW'(lfsr_q[l]));
        end
    end

    // Saturation is applied after every single addition, in input order.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int l = 0; l < LANES; l++) begin
            acc_d[l] = acc_q[l];
            for (int c = 0; c < CHUNK; c++) begin
                idx = 32'(kcnt_q) * CHUNK + 32'(c);
                if (lane_ok[l] && idx < IN_DIM && in_q[IW'(idx)]) begin
                    acc_d[l] = sat_add(acc_d[l],
                                       w_mem_q[AW'(32'(lane_unit[l]) * IN_DIM + idx)]);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            in_q    <= '0;
            mode_q  <= 1'b0;
            group_q <= '0;
            kcnt_q  <= '0;
            for (int l = 0; l < LANES; l++) begin
                acc_q[l]  <= '0;
                lfsr_q[l] <= lfsr_seed(l);
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        in_q    <= in_data_i;
                        mode_q  <= mode_i;
                        out_q   <= '0;
                        group_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StBias;
                    end
                end
                StBias: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_q[l] <= bias_val[l];
                    end
                    kcnt_q  <= '0;
                    state_q <= StAccum;
                end
                StAccum: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc_q[l] <= acc_d[l];
                    end
                    if (kcnt_q == KW'(K - 1)) begin
                        state_q <= StDecide;
                    end else begin
                        kcnt_q <= kcnt_q + 1'b1;
                    end
                end
                StDecide: begin
                    for (int l = 0; l < LANES; l++) begin
                        if (lane_ok[l]) begin
                            out_q[lane_unit[l]] <= dec_bit[l];
                        end
                        lfsr_q[l] <= lfsr_step(lfsr_q[l]);
                    end
                    if (group_q == GW'(G - 1)) begin
                        state_q <= StDone;
                    end else begin
                        group_q <= group_q + 1'b1;
                        state_q <= StBias;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out_data_o = out_q;

endmodule

// File: tb/tb_rbm_layer_par.sv
// Directed bench for rbm_layer_par: expectations are queued at start, a monitor pops them on done.
module tb_rbm_layer_par;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [14:0] in_data;
    logic        wr_en;
    logic        wr_bias;
    logic [6:0]  wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic [4:0]  out_data;

    int errors = 0;
    int checks = 0;
    int n_done = 0;
    logic [4:0] exp_q[$];

    rbm_layer_par dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .mode_i     (mode),
        .in_data_i  (in_data),
        .wr_en_i    (wr_en),
        .wr_bias_i  (wr_bias),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .busy_o     (busy),
        .done_o     (done),
        .out_data_o (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [4:0] e;
            n_done++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got=%b required=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data run%0d got=%b required=%b", n_done, out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic wr(input logic b, input int a, input int v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_bias = b;
        wr_addr = 7'(a);
        wr_data = 12'(v);
    endtask

    task automatic wr_idle();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic set_weights(input int v);
        for (int a = 0; a < 75; a++) wr(1'b0, a, v);
        wr_idle();
    endtask

    task automatic set_biases(input int v);
        for (int o = 0; o < 5; o++) wr(1'b1, o, v);
        wr_idle();
    endtask

    task automatic run(input logic [14:0] din, input logic m, input logic [4:0] e);
        int seen;
        int i;
        @(negedge clk);
        start   = 1'b1;
        in_data = din;
        mode    = m;
        exp_q.push_back(e);
        seen = n_done;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (n_done == seen && i < 60) begin
            @(negedge clk);
            i++;
        end
        if (n_done == seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=none required=done");
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int lat;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; in_data = '0;
        wr_en = 1'b0; wr_bias = 1'b0; wr_addr = '0; wr_data = '0;
        #17;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_out", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Threshold sign around zero.
        set_weights(1);
        set_biases(-7);
        run(15'h7fff, 1'b1, 5'b11111);
        set_biases(-16);
        run(15'h7fff, 1'b1, 5'b00000);

        // Saturation without wrap.
        set_weights(2047);
        set_biases(0);
        run(15'h7fff, 1'b1, 5'b11111);
        set_weights(-2048);
        run(15'h7fff, 1'b1, 5'b00000);

        // Last input of the final (partial) chunk.
        set_weights(0);
        for (int o = 0; o < 5; o++) wr(1'b0, o * 15 + 14, 5);
        wr_idle();
        set_biases(-5);
        run(15'h4000, 1'b1, 5'b11111);
        run(15'h0000, 1'b1, 5'b00000);

        // Write coinciding with start is visible to that run.
        @(negedge clk);
        wr_en = 1'b1; wr_bias = 1'b1; wr_addr = 7'd0; wr_data = 12'd10;
        start = 1'b1; in_data = 15'h0000; mode = 1'b1;
        exp_q.push_back(5'b00001);
        seen = n_done;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < 40 && n_done == seen; i++) @(negedge clk);
        chk("coincident_write_done", 32'(n_done), 32'(seen + 1));
        wr(1'b1, 0, -5);
        wr_idle();

        // Latency, plus ignored start/write pulses while busy and in the DONE state.
        @(negedge clk);
        start = 1'b1; in_data = 15'h4000; mode = 1'b1;
        exp_q.push_back(5'b11111);
        seen = n_done;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 22; n++) begin
            @(posedge clk);
            #1;
            if (done && lat == 0) lat = n;
            case (n)
                1: chk("busy_after_start", 32'(busy), 1);
                3: begin
                    start = 1'b1; in_data = 15'h0000; mode = 1'b0;
                    wr_en = 1'b1; wr_bias = 1'b0; wr_addr = 7'd14; wr_data = 12'(-100);
                end
                4: begin
                    start = 1'b0; wr_bias = 1'b1; wr_addr = 7'd0; wr_data = 12'd100;
                end
                5: wr_en = 1'b0;
                18: begin
                    chk("busy_before_done", 32'(busy), 1);
                    start = 1'b1; in_data = 15'h0000;
                end
                19: begin
                    start = 1'b0;
                    chk("busy_low_at_done", 32'(busy), 0);
                end
                20: chk("done_one_cycle", 32'(done), 0);
                default: ;
            endcase
        end
        chk("latency_edges", 32'(lat), 19);
        chk("single_done", 32'(n_done), 32'(seen + 1));
        run(15'h4000, 1'b1, 5'b11111);
        run(15'h0000, 1'b1, 5'b00000);

        // Stochastic mode at the bottom of the sigmoid never fires.
        set_weights(0);
        set_biases(-2048);
        for (int r = 0; r < 50; r++) run(15'h7fff, 1'b0, 5'b00000);

        // Reset during ACCUM of the second group aborts the run.
        set_weights(1);
        wr(1'b1, 0, -7);
        wr(1'b1, 1, -7);
        wr(1'b1, 2, -16);
        wr(1'b1, 3, -16);
        wr(1'b1, 4, -16);
        wr_idle();
        @(negedge clk);
        start = 1'b1; in_data = 15'h7fff; mode = 1'b1;
        seen = n_done;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("partial_before_reset", 32'(out_data), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_out", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", 32'(n_done), 32'(seen));
        run(15'h7fff, 1'b1, 5'b00011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rbm_layer_par.md
RBM_LAYER_PAR -- requirements
Module: rbm_layer_par

Interface
REQ-001 The block SHALL take parameter IN_DIM, default 15, meaning the visible-unit count (input bits).
REQ-002 The block SHALL take parameter OUT_DIM, default 5, meaning the hidden-unit count (output bits).
REQ-003 The block SHALL take parameter W_BITS, default 12, meaning the signed weight, bias and accumulator width.
REQ-004 The block SHALL take parameter SIG_BITS, default 8, meaning the sigmoid output width and the random-number width.
REQ-005 The block SHALL take parameter CHUNK, default 4, meaning the number of inputs summed per cycle per lane.
REQ-006 The block SHALL take parameter LANES, default 2, meaning the number of output units computed in parallel.
REQ-007 The block SHALL take parameter SEED, default 8'h20, meaning the base LFSR seed.
REQ-008 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 The block SHALL have port start, input, 1 bit: single-cycle request to evaluate the layer.
REQ-011 The block SHALL have port mode, input, 1 bit: 0 = stochastic sampling, 1 = deterministic threshold; sampled with start.
REQ-012 The block SHALL have port in_data, input, IN_DIM bits: visible vector; sampled with start.
REQ-013 The block SHALL have port wr_en, input, 1 bit: parameter write strobe.
REQ-014 The block SHALL have port wr_bias, input, 1 bit: 1 = write a bias, 0 = write a weight.
REQ-015 The block SHALL have port wr_addr, input, clog2(IN_DIM*OUT_DIM) bits: weight index o*IN_DIM+i, or bias index o.
REQ-016 The block SHALL have port wr_data, input, W_BITS bits: signed value to write.
REQ-017 The block SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-018 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-019 The block SHALL have port out_data, output, OUT_DIM bits: hidden vector, stable from done until the next accepted start.

Function
REQ-020 FSM states SHALL be IDLE, BIAS, ACCUM, DECIDE and DONE; the derived counts are K = ceil(IN_DIM/CHUNK) and G = ceil(OUT_DIM/LANES).
REQ-021 In IDLE, start SHALL be accepted: latch in_data and mode, clear out_data, group = 0, then go to BIAS.
REQ-022 BIAS (1 cycle) SHALL load each lane accumulator with the bias of its unit, group*LANES+lane.
REQ-023 ACCUM (K cycles) SHALL add, per lane, the weights of CHUNK consecutive inputs whose in_data bit is 1; inputs with index >= IN_DIM contribute 0.
REQ-024 Every single addition SHALL saturate to [-2^(W_BITS-1), 2^(W_BITS-1)-1], applied in chain order with no wrap-around.
REQ-025 DECIDE (1 cycle) SHALL write one bit per lane: mode 1 gives acc >= 0; mode 0 gives sigmoid(acc) > lfsr[lane]; lanes with unit index >= OUT_DIM write nothing.
REQ-026 After DECIDE, the FSM SHALL return to BIAS with group+1 if group < G-1, else go to DONE.
REQ-027 DONE SHALL assert done for exactly 1 cycle, deassert busy and return to IDLE.
REQ-028 Latency: done SHALL be high in the cycle following the G*(K+2)+1th rising edge after the edge sampling start (19 with defaults).
REQ-029 start SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-030 wr_en SHALL be honoured only in IDLE; writes while busy and out-of-range addresses SHALL be dropped silently.
REQ-031 If wr_en and start coincide in IDLE, the write SHALL complete first and the new value SHALL be used by this evaluation.
REQ-032 Each lane SHALL have an 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seeded SEED^lane (8'h01 if that is 0), advancing once per DECIDE, never reaching 0.
REQ-033 The sigmoid SHALL map W_BITS signed to SIG_BITS unsigned, monotonic non-decreasing, with sigmoid(-2^(W_BITS-1)) = 0.

Reset
REQ-034 reset low SHALL immediately force: FSM = IDLE, busy = 0, done = 0, out_data = 0, accumulators = 0, LFSRs = seeds.
REQ-035 Weight and bias storage SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-evaluation SHALL abort it; no done SHALL follow.

Verification
REQ-037 Bench SHALL cover: all weights 1, biases -7, in_data all ones, mode 1 -> out_data 5'b11111; biases -16 -> 5'b00000.
REQ-038 Bench SHALL cover: all weights 2047, bias 0, in_data all ones, mode 1 -> 5'b11111; all weights -2048 -> 5'b00000 (saturated, no wrap).
REQ-039 Bench SHALL cover: only weight i=14 nonzero (=5), bias -5, in_data = bit 14 only -> 5'b11111; in_data = 0 -> 5'b00000.
REQ-040 Bench SHALL cover: start at edge 0 -> done high exactly after edge 19; extra start and wr_en pulses while busy -> no effect on result or memory.
REQ-041 Bench SHALL cover: biases -2048, weights 0, mode 0, 50 back-to-back runs -> out_data 5'b00000 every run.
REQ-042 Bench SHALL cover: reset low during ACCUM -> busy = 0, done = 0, out_data = 0 immediately; a following run -> correct result with the preloaded weights.
